// File: rtl/bcd_mux_display_driver_if.sv
// Load port of the multiplexed 7-segment driver: packed digit codes and
// decimal points offered under a load/ready handshake.
interface bcd_mux_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic                      ready;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;

    modport master (
        output load,
        output value_in,
        output dp_in,
        input  ready
    );

    modport slave (
        input  load,
        input  value_in,
        input  dp_in,
        output ready
    );
endinterface

// File: rtl/bcd_mux_display_driver.sv
// Time-multiplexed N-digit 7-segment driver with a double-buffered value that
// only changes at frame boundaries, hex glyphs, leading-zero blanking and polarity select.
module bcd_mux_display_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          HEX_EN      = 1'b1,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_mux_display_driver_if.slave   ld_bus,
    input  logic                      lz_suppress,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    typedef enum logic {
        StReady,
        StPending
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_frame_end;
    logic                    w_accept;
    logic                    w_commit;
    logic [3:0]              w_code;
    logic [NUM_DIGITS-1:0]   w_lead;
    logic                    w_blank;
    logic [6:0]              w_glyph;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB:    g = HEX_EN ? 7'b0011111 : 7'b0000000;
            4'hC:    g = HEX_EN ? 7'b1001110 : 7'b0000000;
            4'hD:    g = HEX_EN ? 7'b0111101 : 7'b0000000;
            4'hE:    g = HEX_EN ? 7'b1001111 : 7'b0000000;
            default: g = HEX_EN ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    assign w_tick      = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_accept    = (r_state == StReady) && ld_bus.load;
    assign w_commit    = (r_state == StPending) && w_frame_end;
    assign ld_bus.ready = (r_state == StReady);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StReady:   if (ld_bus.load) w_state_next = StPending;
            StPending: if (w_frame_end) w_state_next = StReady;
            default:   w_state_next = StReady;
        endcase
    end

    // w_lead[i] is set when digits NUM_DIGITS-1 down to i are all zero.
    always_comb begin : p_lead
        logic acc;
        acc    = 1'b1;
        w_lead = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc       = acc & (r_disp_val[4*i +: 4] == 4'd0);
            w_lead[i] = acc;
        end
    end

    assign w_code  = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_blank = lz_suppress && (r_idx != '0) && w_lead[r_idx];
    assign w_glyph = w_blank ? 7'b0000000 : glyph(w_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StReady;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end
        end
    end

    // A load taken in the frame_end cycle lands in pending only, so it waits a full frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
        end else begin
            if (w_accept) begin
                r_pend_val <= ld_bus.value_in;
                r_pend_dp  <= ld_bus.dp_in;
            end
            if (w_commit) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= '0;
            r_dp  <= 1'b0;
            r_an  <= '0;
        end else begin
            r_seg <= w_glyph;
            r_dp  <= r_disp_dp[r_idx];
            r_an  <= NUM_DIGITS'(1) << r_idx;
        end
    end

    assign seg = r_seg ^ {7{ACTIVE_LOW}};
    assign dp  = r_dp ^ ACTIVE_LOW;
    assign an  = r_an ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_bcd_mux_display_driver.sv
// Scoreboard bench: three drivers (hex, no-hex, active-low) share one stimulus;
// expected digit slots are queued by the stimulus and checked by a monitor.
module tb_bcd_mux_display_driver;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G9 = 7'b1110011;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GB = 7'b0011111;
    localparam logic [6:0] GC = 7'b1001110;
    localparam logic [6:0] GF = 7'b1000111;
    localparam logic [6:0] BL = 7'b0000000;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] segh;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpv;
    logic        lz;

    logic [6:0] seg_m, seg_h, seg_a;
    logic       dp_m, dp_h, dp_a;
    logic [3:0] an_m, an_h, an_a;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    bcd_mux_display_driver_if #(.NUM_DIGITS(4)) bus_m ();
    bcd_mux_display_driver_if #(.NUM_DIGITS(4)) bus_h ();
    bcd_mux_display_driver_if #(.NUM_DIGITS(4)) bus_a ();

    assign bus_m.load = load;  assign bus_m.value_in = value;  assign bus_m.dp_in = dpv;
    assign bus_h.load = load;  assign bus_h.value_in = value;  assign bus_h.dp_in = dpv;
    assign bus_a.load = load;  assign bus_a.value_in = value;  assign bus_a.dp_in = dpv;

    bcd_mux_display_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1), .ACTIVE_LOW(1'b0))
        dut_m (.clk(clk), .rst(rst), .ld_bus(bus_m), .lz_suppress(lz),
               .seg(seg_m), .dp(dp_m), .an(an_m));
    bcd_mux_display_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0), .ACTIVE_LOW(1'b0))
        dut_h (.clk(clk), .rst(rst), .ld_bus(bus_h), .lz_suppress(lz),
               .seg(seg_h), .dp(dp_h), .an(an_h));
    bcd_mux_display_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1), .ACTIVE_LOW(1'b1))
        dut_a (.clk(clk), .rst(rst), .ld_bus(bus_a), .lz_suppress(lz),
               .seg(seg_a), .dp(dp_a), .an(an_a));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slot order is {d3,d2,d1,d0} in s/sh; one entry per digit, digit 0 first.
    task automatic push_frame(input logic [27:0] s, input logic [27:0] sh, input logic [3:0] d);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.an   = 4'b0001 << i;
            e.seg  = s[7*i +: 7];
            e.segh = sh[7*i +: 7];
            e.dp   = d[i];
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns in the first cycle an=0001 is visible, 14 cycles before the next frame_end.
    task automatic sync_frame();
        logic [3:0] p;
        int n;
        bit found;
        p = an_m;
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            step();
            if (an_m == 4'b0001 && p != 4'b0001) found = 1'b1;
            p = an_m;
            n++;
        end
        if (!found) chk("sync_timeout", 32'(an_m), 32'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic load_at(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dpv   = d;
        step();
        load  = 1'b0;
    endtask

    initial begin : monitor
        logic [3:0] prev_an;
        int len;
        exp_t e;
        prev_an = 4'b0000;
        len = 0;
        forever begin
            @(negedge clk);
            if (an_m != prev_an && an_m != 4'b0000) begin
                if (prev_an != 4'b0000) chk("slot_len", 32'(len), 32'd4);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("an", 32'(an_m), 32'(e.an));
                    chk("seg", 32'(seg_m), 32'(e.seg));
                    chk("dp", 32'(dp_m), 32'(e.dp));
                    chk("nohex_seg", 32'({an_h, seg_h, dp_h}), 32'({e.an, e.segh, e.dp}));
                    chk("actlow_out", 32'({an_a, seg_a, dp_a}), 32'({~e.an, ~e.seg, ~e.dp}));
                end
                len = 0;
            end
            prev_an = an_m;
            len++;
        end
    end

    initial begin : stim
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        dpv   = 4'b0000;
        lz    = 1'b0;

        // Reset: outputs inactive, ready high, then a zero display scanning.
        steps(3);
        chk("rst_ready", 32'(bus_m.ready), 32'd1);
        chk("rst_an", 32'(an_m), 32'd0);
        chk("rst_seg", 32'(seg_m), 32'd0);
        chk("rst_dp", 32'(dp_m), 32'd0);
        chk("rst_al_out", 32'({an_a, seg_a, dp_a}), 32'({4'b1111, 7'b1111111, 1'b1}));
        push_frame({G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'b0000);
        push_frame({G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'b0000);
        rst = 1'b0;
        drain();

        // Mid-frame load: old value holds until frame_end, ready low meanwhile.
        sync_frame();
        push_frame({G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'b0000);
        push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000);
        steps(2);
        chk("ready_idle", 32'(bus_m.ready), 32'd1);
        load_at(16'h1234, 4'b0000);
        chk("ready_busy", 32'(bus_m.ready), 32'd0);
        steps(11);
        chk("ready_hold", 32'(bus_m.ready), 32'd0);
        step();
        chk("ready_back", 32'(bus_m.ready), 32'd1);
        drain();

        // Load while busy is ignored.
        sync_frame();
        push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000);
        push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000);
        steps(2);
        load_at(16'h1234, 4'b0000);
        step();
        chk("busy_ready", 32'(bus_m.ready), 32'd0);
        load_at(16'h5678, 4'b0000);
        drain();

        // Load in the frame_end cycle shows one full frame later.
        sync_frame();
        push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000);
        push_frame({G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'b0000);
        push_frame({G9, G9, G9, G9}, {G9, G9, G9, G9}, 4'b0000);
        steps(14);
        chk("fe_ready", 32'(bus_m.ready), 32'd1);
        load_at(16'h9999, 4'b0000);
        chk("fe_busy", 32'(bus_m.ready), 32'd0);
        drain();

        // Leading zeros, dp on a blanked digit, and all-zero value.
        lz = 1'b1;
        sync_frame();
        push_frame({G9, G9, G9, G9}, {G9, G9, G9, G9}, 4'b0000);
        push_frame({BL, BL, G7, G0}, {BL, BL, G7, G0}, 4'b1000);
        steps(2);
        load_at(16'h0070, 4'b1000);
        drain();
        sync_frame();
        push_frame({BL, BL, G7, G0}, {BL, BL, G7, G0}, 4'b1000);
        push_frame({BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000);
        steps(2);
        load_at(16'h0000, 4'b0000);
        drain();

        // Hex glyphs; the no-hex driver blanks them but keeps dp.
        sync_frame();
        push_frame({BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000);
        push_frame({GA, GB, GC, GF}, {BL, BL, BL, BL}, 4'b1000);
        steps(2);
        load_at(16'hABCF, 4'b1000);
        drain();

        // dp on one digit; inner zero not suppressed.
        sync_frame();
        push_frame({GA, GB, GC, GF}, {BL, BL, BL, BL}, 4'b1000);
        push_frame({BL, G3, G0, G5}, {BL, G3, G0, G5}, 4'b0100);
        steps(2);
        load_at(16'h0305, 4'b0100);
        drain();

        // Reset with a pending load discards it.
        sync_frame();
        steps(2);
        load_at(16'h8888, 4'b0000);
        chk("pend_busy", 32'(bus_m.ready), 32'd0);
        steps(2);
        rst = 1'b1;
        step();
        chk("mrst_ready", 32'(bus_m.ready), 32'd1);
        chk("mrst_out", 32'({an_m, seg_m, dp_m}), 32'd0);
        chk("mrst_al_an", 32'(an_a), 32'hF);
        push_frame({BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000);
        push_frame({BL, BL, BL, G0}, {BL, BL, BL, G0}, 4'b0000);
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
